seq_adder_nbit: RTL

SEQ_ADDER_NBIT -- requirements
Module: seq_adder_nbit

---
 rtl/seq_adder_pkg.sv | 18 +
 rtl/fa_chunk.sv | 23 ++
 rtl/seq_adder_nbit.sv | 111 +++++++++++
 3 files changed

// File: rtl/seq_adder_pkg.sv
// Shared definitions for the sequential chunked adder: FSM encoding and default geometry.
package seq_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int unsigned DEFAULT_WIDTH = 8;
  localparam int unsigned DEFAULT_CHUNK = 2;

  // Chunk index must be able to count 0..N-1; always at least one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/fa_chunk.sv
// Combinational ripple of CHUNK full adders; one slice of the sequential addition.
module fa_chunk #(
  parameter int unsigned CHUNK = 2
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             ci,
  output logic [CHUNK-1:0] s,
  output logic             co
);

  always_comb begin
    logic c;
    c = ci;
    s = '0;
    for (int i = 0; i < int'(CHUNK); i++) begin
      s[i] = a[i] ^ b[i] ^ c;
      c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    co = c;
  end

endmodule

// File: rtl/seq_adder_nbit.sv
// Multi-cycle adder: adds CHUNK bits per cycle over WIDTH/CHUNK cycles.
// Define SEQ_ADDER_OVF_EN to add the registered signed-overflow output ovf.
module seq_adder_nbit
  import seq_adder_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH,
  parameter int unsigned CHUNK = DEFAULT_CHUNK
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             co
`ifdef SEQ_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned N    = WIDTH / CHUNK;
  localparam int unsigned IDXW = idx_width(N);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q, s_q;
  logic             carry_q, co_q;
  logic [IDXW-1:0]  idx_q;

  logic [CHUNK-1:0] a_chunk, b_chunk, sum_chunk;
  logic             carry_out;
  logic [31:0]      base;
  logic             accept, last;

  assign accept = start && (state_q != RUN);
  assign last   = (idx_q == IDXW'(N - 1));

  always_comb begin
    base    = 32'(idx_q) * CHUNK;
    a_chunk = a_q[base +: CHUNK];
    b_chunk = b_q[base +: CHUNK];
  end

  fa_chunk #(
    .CHUNK(CHUNK)
  ) u_fa_chunk (
    .a (a_chunk),
    .b (b_chunk),
    .ci(carry_q),
    .s (sum_chunk),
    .co(carry_out)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: state_d = start ? RUN : IDLE;
      RUN:        state_d = last ? DONE : RUN;
      default:    state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      carry_q <= 1'b0;
      co_q    <= 1'b0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        a_q     <= a;
        b_q     <= b;
        carry_q <= ci;
        idx_q   <= '0;
      end else if (state_q == RUN) begin
        s_q[base +: CHUNK] <= sum_chunk;
        carry_q            <= carry_out;
        idx_q              <= idx_q + IDXW'(1);
        if (last) co_q <= carry_out;
      end
    end
  end

`ifdef SEQ_ADDER_OVF_EN
  logic ovf_q;

  // The final chunk's MSB is the sum's sign bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (!accept && state_q == RUN && last) begin
      ovf_q <= (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum_chunk[CHUNK-1] != a_q[WIDTH-1]);
    end
  end

  assign ovf = ovf_q;
`endif

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign s    = s_q;
  assign co   = co_q;

endmodule
